coin_pulser: RTL and testbench
==============================

COIN_PULSER -- requirements
Module: coin_pulser

Interface
REQ-001 Parameter CLKDIV, default 12000: CLK cycles per timing tick (1 ms at 12 MHz).
REQ-002 Parameter DEB_TICKS, default 8: ticks a button must be stable before the debouncer accepts the new level.
REQ-003 Parameter PULSE_TICKS, default 50: coin pulse width in ticks.
REQ-004 Parameter LOCK_TICKS, default 100: post-pulse lockout in ticks.
REQ-005 CLK  in  1  sole clock; all logic on rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 coin_btn1  in  1  player-1 coin request, active high, asynchronous to CLK.
REQ-008 coin_btn2  in  1  player-2 coin request, active high, asynchronous to CLK.
REQ-009 coin1_n  out  1  coin switch 1 to game core, active low.
REQ-010 coin2_n  out  1  coin switch 2 to game core, active low.
REQ-011 busy  out  1  high while either channel is not in IDLE.
REQ-012 coin_count  out  8  total accepted coins, both channels.

Function
REQ-013 Each button passes a 2-flop synchronizer before any other logic.
REQ-014 Tick generator: counter 0..CLKDIV-1, one-cycle tick when the counter equals CLKDIV-1, then wraps to 0.
REQ-015 Debouncer per channel: debounced level changes only after DEB_TICKS consecutive ticks with the synchronized input differing from the debounced level; any agreeing sample clears the stability count.
REQ-016 Per-channel FSM states: IDLE, PULSE, LOCK, RELEASE.
REQ-017 IDLE -> PULSE on the cycle after the debounced level rises; the tick counter loads PULSE_TICKS.
REQ-018 PULSE: coinN_n = 0; the counter decrements on each tick; PULSE -> LOCK when it reaches 0, loading LOCK_TICKS.
REQ-019 LOCK: coinN_n = 1; decrements on each tick; LOCK -> RELEASE at 0.
REQ-020 RELEASE -> IDLE when the debounced level is 0; a held button never produces a second pulse.
REQ-021 Presses arriving in PULSE, LOCK or RELEASE are ignored, not queued.
REQ-022 coinN_n is registered and low only in PULSE; pulse width = PULSE_TICKS ticks, within ±1 tick.
REQ-023 coin_count increments by 1 per IDLE->PULSE entry and wraps 255 -> 0.
REQ-024 Simultaneous entry on both channels in one cycle increments coin_count by 2.
REQ-025 The channels are fully independent; the pulses may overlap.
REQ-026 busy is the registered OR of (state != IDLE) over both channels.

Reset
REQ-027 While RESET is high: both FSMs IDLE, coin1_n = coin2_n = 1, busy = 0, coin_count = 0, tick counter = 0.
REQ-028 RESET also clears the synchronizers and debounced levels to 0, and clears the stability counts.
REQ-029 RESET asserted mid-PULSE releases coinN_n to 1 on the next edge.
REQ-030 A button held through reset deassertion pulses only after a full debounce (DEB_TICKS ticks).

Verification (CLKDIV=4, DEB_TICKS=2, PULSE_TICKS=3, LOCK_TICKS=4)
REQ-031 Single press: hold coin_btn1 high for 40 cycles -> coin1_n low for 12±4 cycles, one pulse only, coin_count = 1, coin2_n stays 1.
REQ-032 Glitch: coin_btn2 high for 5 cycles (under 2 ticks) -> no pulse, coin_count = 0.
REQ-033 Re-press in lockout: press btn1, release, and press again during LOCK -> exactly one pulse; a press after RELEASE->IDLE yields a second pulse, coin_count = 2.
REQ-034 Simultaneous: both buttons rise on the same cycle -> overlapping pulses, coin_count jumps from 0 to 2 in one cycle.
REQ-035 Wrap: 256 accepted coins -> coin_count = 0, busy returns to 0 after the last pulse.
REQ-036 Reset mid-pulse: RESET for 1 cycle during PULSE -> coin1_n = 1 on the next edge, coin_count = 0, state IDLE.

Source files
------------

// File: rtl/coin_pulser.sv
// coin_pulser: turns two asynchronous coin buttons into clean, fixed-width,
// active-low coin-switch pulses for a game core.
//
// Each channel: 2-flop synchronizer -> tick-based debouncer -> FSM
// (IDLE -> PULSE -> LOCK -> RELEASE). One pulse per debounced press; presses
// during PULSE/LOCK/RELEASE are dropped, and a held button must be released
// before it can produce another pulse.
//
// Parameters
//   CLKDIV      CLK cycles per timing tick
//   DEB_TICKS   tick intervals a new button level must persist to be accepted
//   PULSE_TICKS coin pulse width in ticks
//   LOCK_TICKS  post-pulse lockout in ticks
// Ports
//   CLK         sole clock, rising edge
//   RESET       synchronous, active-high reset
//   coin_btn1/2 raw coin requests, active high, asynchronous to CLK
//   coin1_n/2_n registered coin switches, active low (low only in PULSE)
//   busy        registered: high while either channel is not IDLE
//   coin_count  accepted coins over both channels, wraps 255 -> 0
module coin_pulser #(
  parameter int CLKDIV      = 12000,
  parameter int DEB_TICKS   = 8,
  parameter int PULSE_TICKS = 50,
  parameter int LOCK_TICKS  = 100
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       coin_btn1,
  input  logic       coin_btn2,
  output logic       coin1_n,
  output logic       coin2_n,
  output logic       busy,
  output logic [7:0] coin_count
);

  localparam int TICK_W    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int DEB_W     = $clog2(DEB_TICKS + 1);
  localparam int MAX_TICKS = (PULSE_TICKS > LOCK_TICKS) ? PULSE_TICKS : LOCK_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKDIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_TICKS);
  localparam logic [CNT_W-1:0]  PULSE_LD  = CNT_W'(PULSE_TICKS);
  localparam logic [CNT_W-1:0]  LOCK_LD   = CNT_W'(LOCK_TICKS);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_LOCK    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  logic [1:0]        meta_r;
  logic [1:0]        sync_r;
  logic [TICK_W-1:0] tick_cnt_r;
  logic              tick_s;
  logic [DEB_W-1:0]  stab_r [2];
  logic [1:0]        deb_r;
  logic [1:0]        deb_prev_r;
  state_t            state_r [2];
  state_t            state_nxt_s [2];
  logic [CNT_W-1:0]  cnt_r [2];
  logic [CNT_W-1:0]  cnt_nxt_s [2];
  logic [1:0]        entry_s;
  logic [1:0]        coin_n_r;
  logic              busy_r;
  logic [7:0]        count_r;

  // Two-flop synchronizer for both buttons (bit 0 = channel 1).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      meta_r <= 2'b00;
      sync_r <= 2'b00;
    end else begin
      meta_r <= {coin_btn2, coin_btn1};
      sync_r <= meta_r;
    end
  end

  assign tick_s = (tick_cnt_r == TICK_LAST);

  // Free-running tick divider, 0..CLKDIV-1.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {TICK_W{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  // Debouncer: the first differing tick starts the count, so a new level is
  // accepted only after it has persisted across DEB_TICKS whole tick
  // intervals; a glitch shorter than that can never be accepted regardless of
  // tick phase. Any cycle agreeing with the debounced level restarts it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      deb_r      <= 2'b00;
      deb_prev_r <= 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
        stab_r[ch] <= {DEB_W{1'b0}};
      end
    end else begin
      deb_prev_r <= deb_r;
      for (int ch = 0; ch < 2; ch++) begin
        if (sync_r[ch] == deb_r[ch]) begin
          stab_r[ch] <= {DEB_W{1'b0}};
        end else if (tick_s) begin
          if (stab_r[ch] == DEB_LAST) begin
            deb_r[ch]  <= sync_r[ch];
            stab_r[ch] <= {DEB_W{1'b0}};
          end else begin
            stab_r[ch] <= stab_r[ch] + DEB_W'(1);
          end
        end else begin
          stab_r[ch] <= stab_r[ch];
        end
      end
    end
  end

  // Per-channel next-state and tick-counter logic.
  always_comb begin
    entry_s = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      state_nxt_s[ch] = state_r[ch];
      cnt_nxt_s[ch]   = cnt_r[ch];
      case (state_r[ch])
        ST_IDLE: begin
          // Only a fresh rising edge starts a pulse, never a held level.
          if (deb_r[ch] && !deb_prev_r[ch]) begin
            state_nxt_s[ch] = ST_PULSE;
            cnt_nxt_s[ch]   = PULSE_LD;
            entry_s[ch]     = 1'b1;
          end else begin
            state_nxt_s[ch] = ST_IDLE;
          end
        end
        ST_PULSE: begin
          if (tick_s) begin
            if (cnt_r[ch] <= CNT_ONE) begin
              state_nxt_s[ch] = ST_LOCK;
              cnt_nxt_s[ch]   = LOCK_LD;
            end else begin
              cnt_nxt_s[ch] = cnt_r[ch] - CNT_ONE;
            end
          end else begin
            cnt_nxt_s[ch] = cnt_r[ch];
          end
        end
        ST_LOCK: begin
          if (tick_s) begin
            if (cnt_r[ch] <= CNT_ONE) begin
              state_nxt_s[ch] = ST_RELEASE;
              cnt_nxt_s[ch]   = {CNT_W{1'b0}};
            end else begin
              cnt_nxt_s[ch] = cnt_r[ch] - CNT_ONE;
            end
          end else begin
            cnt_nxt_s[ch] = cnt_r[ch];
          end
        end
        ST_RELEASE: begin
          if (!deb_r[ch]) begin
            state_nxt_s[ch] = ST_IDLE;
          end else begin
            state_nxt_s[ch] = ST_RELEASE;
          end
        end
        default: begin
          state_nxt_s[ch] = ST_IDLE;
          cnt_nxt_s[ch]   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, counters and registered outputs; outputs are taken from the next
  // state so they change on the same edge as the FSM.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int ch = 0; ch < 2; ch++) begin
        state_r[ch] <= ST_IDLE;
        cnt_r[ch]   <= {CNT_W{1'b0}};
      end
      coin_n_r <= 2'b11;
      busy_r   <= 1'b0;
      count_r  <= 8'd0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        state_r[ch]  <= state_nxt_s[ch];
        cnt_r[ch]    <= cnt_nxt_s[ch];
        coin_n_r[ch] <= (state_nxt_s[ch] != ST_PULSE);
      end
      busy_r  <= (state_nxt_s[0] != ST_IDLE) || (state_nxt_s[1] != ST_IDLE);
      count_r <= count_r + {7'd0, entry_s[0]} + {7'd0, entry_s[1]};
    end
  end

  assign coin1_n    = coin_n_r[0];
  assign coin2_n    = coin_n_r[1];
  assign busy       = busy_r;
  assign coin_count = count_r;

endmodule

// File: tb/tb_coin_pulser.sv
// Self-checking bench for coin_pulser with small timing parameters.
// Stimulus pushes expected pulse windows into per-channel queues; a monitor
// measures every completed low pulse and scores it against the queue.
module tb_coin_pulser;

  localparam int CLKDIV = 4;
  localparam int DEB    = 2;
  localparam int PT     = 3;
  localparam int LT     = 4;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       btn1 = 1'b0;
  logic       btn2 = 1'b0;
  wire        coin1_n;
  wire        coin2_n;
  wire        busy;
  wire  [7:0] coin_count;

  always #5 clk = ~clk;

  coin_pulser #(
    .CLKDIV(CLKDIV), .DEB_TICKS(DEB), .PULSE_TICKS(PT), .LOCK_TICKS(LT)
  ) dut (
    .CLK(clk), .RESET(rst), .coin_btn1(btn1), .coin_btn2(btn2),
    .coin1_n(coin1_n), .coin2_n(coin2_n), .busy(busy), .coin_count(coin_count)
  );

  typedef struct {
    int min_w;
    int max_w;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   errors = 0;
  int   checks = 0;
  int   width [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic void expect_pulse(input int ch, input int lo, input int hi);
    exp_t e;
    e.min_w = lo;
    e.max_w = hi;
    if (ch == 0) q1.push_back(e);
    else         q2.push_back(e);
  endfunction

  task automatic score_pulse(input int ch, input int w);
    exp_t e;
    checks++;
    if ((ch == 0 && q1.size() == 0) || (ch == 1 && q2.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_pulse ch%0d: got width %0d, expected no pulse", ch + 1, w);
    end else begin
      if (ch == 0) e = q1.pop_front();
      else         e = q2.pop_front();
      if (w < e.min_w || w > e.max_w) begin
        errors++;
        $display("FAIL pulse_width ch%0d: got %0d, expected %0d..%0d", ch + 1, w, e.min_w, e.max_w);
      end
    end
  endtask

  // Monitor: measure each low pulse on both coin outputs and score it.
  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (((ch == 0) ? coin1_n : coin2_n) === 1'b0) begin
        width[ch] = width[ch] + 1;
      end else if (width[ch] > 0) begin
        score_pulse(ch, width[ch]);
        width[ch] = 0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  initial begin
    int n;
    width[0] = 0;
    width[1] = 0;

    // Reset state
    cycles(3);
    check("rst_coin1_n", coin1_n, 1'b1);
    check("rst_coin2_n", coin2_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", coin_count, 8'd0);
    rst = 1'b0;

    // Single press held 40 cycles: one pulse of 12 +/- 4 cycles
    expect_pulse(0, 8, 16);
    btn1 = 1'b1;
    cycles(40);
    btn1 = 1'b0;
    wait_idle("t1_idle");
    check("t1_count", coin_count, 8'd1);
    check("t1_coin2_n", coin2_n, 1'b1);

    // Glitch of 5 cycles on channel 2: rejected
    do_reset();
    btn2 = 1'b1;
    cycles(5);
    btn2 = 1'b0;
    cycles(40);
    check("t2_count", coin_count, 8'd0);
    check("t2_busy", busy, 1'b0);

    // Re-press during lockout is ignored; press after idle gives second pulse
    do_reset();
    expect_pulse(0, 8, 16);
    btn1 = 1'b1;
    cycles(20);
    btn1 = 1'b0;
    n = 0;
    while (coin1_n !== 1'b1 && n < 40) begin
      cycles(1);
      n++;
    end
    check("t3_pulse_end", coin1_n, 1'b1);
    cycles(1);
    btn1 = 1'b1;
    cycles(30);
    btn1 = 1'b0;
    wait_idle("t3_idle_a");
    check("t3_count_a", coin_count, 8'd1);
    expect_pulse(0, 8, 16);
    btn1 = 1'b1;
    cycles(20);
    btn1 = 1'b0;
    wait_idle("t3_idle_b");
    check("t3_count_b", coin_count, 8'd2);

    // Simultaneous press: count jumps 0 -> 2, pulses overlap
    do_reset();
    expect_pulse(0, 8, 16);
    expect_pulse(1, 8, 16);
    btn1 = 1'b1;
    btn2 = 1'b1;
    n = 0;
    while (coin_count === 8'd0 && n < 40) begin
      cycles(1);
      n++;
    end
    check("t4_count_jump", coin_count, 8'd2);
    check("t4_both_low", {coin2_n, coin1_n}, 2'b00);
    cycles(10);
    btn1 = 1'b0;
    btn2 = 1'b0;
    wait_idle("t4_idle");

    // Wrap: 256 accepted coins as 128 simultaneous pairs
    do_reset();
    for (int i = 0; i < 128; i++) begin
      if (i == 127) check("t5_count_254", coin_count, 8'd254);
      expect_pulse(0, 8, 16);
      expect_pulse(1, 8, 16);
      btn1 = 1'b1;
      btn2 = 1'b1;
      cycles(20);
      btn1 = 1'b0;
      btn2 = 1'b0;
      wait_idle("t5_idle");
    end
    check("t5_count_wrap", coin_count, 8'd0);
    check("t5_busy", busy, 1'b0);

    // Reset mid-pulse, then button held through reset release
    do_reset();
    expect_pulse(0, 1, 16);
    btn1 = 1'b1;
    n = 0;
    while (coin1_n !== 1'b0 && n < 40) begin
      cycles(1);
      n++;
    end
    check("t6_pulse_start", coin1_n, 1'b0);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    check("t6_rst_coin1_n", coin1_n, 1'b1);
    check("t6_rst_count", coin_count, 8'd0);
    check("t6_rst_busy", busy, 1'b0);
    rst = 1'b0;
    expect_pulse(0, 8, 16);
    n = 0;
    while (coin1_n === 1'b1 && n < 60) begin
      cycles(1);
      n++;
    end
    check_range("t6_held_delay", n, DEB * CLKDIV, 59);
    btn1 = 1'b0;
    wait_idle("t6_idle");
    check("t6_count", coin_count, 8'd1);

    // Every expected pulse must have been seen
    cycles(20);
    check("missing_pulses_ch1", q1.size(), 0);
    check("missing_pulses_ch2", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
